// File: rtl/metadata_array_nway_pkg.sv
// rtl/metadata_array_nway_pkg.sv - shared types and constants for the n-way metadata array
package metadata_array_nway_pkg;

    // Widest tag / coherence fields the metadata carrier can hold; instances narrow these.
    localparam int TAG_MAX_W = 32;
    localparam int COH_MAX_W = 8;

    // Coherence state that marks an entry as invalid.
    localparam logic [COH_MAX_W-1:0] COH_INVALID = '0;

    // One way's metadata, zero-extended into max-width fields.
    typedef struct packed {
        logic [TAG_MAX_W-1:0] tag;
        logic [COH_MAX_W-1:0] coh_state;
    } meta_t;

    // Controller state: CLEAR sweeps the array, IDLE serves requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/metadata_array_nway_if.sv
// rtl/metadata_array_nway_if.sv - request/response bundle for the n-way metadata array
interface metadata_array_nway_if #(
    parameter int NSETS = 128,
    parameter int NWAYS = 4,
    parameter int TAG_W = 19,
    parameter int COH_W = 2
);
    localparam int IDX_W = $clog2(NSETS);

    logic                     io_read_valid;
    logic                     io_read_ready;
    logic [IDX_W-1:0]         io_read_bits_idx;
    logic [TAG_W-1:0]         io_read_bits_tag;

    logic                     io_write_valid;
    logic                     io_write_ready;
    logic [IDX_W-1:0]         io_write_bits_idx;
    logic [NWAYS-1:0]         io_write_bits_way_en;
    logic [TAG_W-1:0]         io_write_bits_data_tag;
    logic [COH_W-1:0]         io_write_bits_data_coh_state;

    logic                     io_flush_valid;
    logic                     io_flush_ready;

    logic                     io_resp_valid;
    logic [NWAYS*TAG_W-1:0]   io_resp_tag;
    logic [NWAYS*COH_W-1:0]   io_resp_coh_state;
    logic [NWAYS-1:0]         io_resp_hit;

    logic                     io_busy;

    modport master (
        output io_read_valid, io_read_bits_idx, io_read_bits_tag,
        output io_write_valid, io_write_bits_idx, io_write_bits_way_en,
        output io_write_bits_data_tag, io_write_bits_data_coh_state,
        output io_flush_valid,
        input  io_read_ready, io_write_ready, io_flush_ready,
        input  io_resp_valid, io_resp_tag, io_resp_coh_state, io_resp_hit,
        input  io_busy
    );

    modport slave (
        input  io_read_valid, io_read_bits_idx, io_read_bits_tag,
        input  io_write_valid, io_write_bits_idx, io_write_bits_way_en,
        input  io_write_bits_data_tag, io_write_bits_data_coh_state,
        input  io_flush_valid,
        output io_read_ready, io_write_ready, io_flush_ready,
        output io_resp_valid, io_resp_tag, io_resp_coh_state, io_resp_hit,
        output io_busy
    );

endinterface

// File: rtl/metadata_way_ram.sv
// rtl/metadata_way_ram.sv - one way of metadata storage, single write port, registered read
module metadata_way_ram #(
    parameter int NSETS  = 128,
    parameter int ADDR_W = 7,
    parameter int WIDTH  = 21
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [NSETS];

    // Storage and read register carry no reset; the read register holds between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/metadata_array_nway.sv
// rtl/metadata_array_nway.sv - n-way tag/coherence metadata array with clear sweep and hit compare
module metadata_array_nway
    import metadata_array_nway_pkg::*;
#(
    parameter int NSETS = 128,
    parameter int NWAYS = 4,
    parameter int TAG_W = 19,
    parameter int COH_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    metadata_array_nway_if.slave bus
);

    localparam int IDX_W = $clog2(NSETS);
    localparam int MW    = TAG_W + COH_W;
    localparam logic [IDX_W:0] LAST_SET = (IDX_W+1)'(NSETS - 1);

    state_e           state;
    state_e           state_nxt;
    logic [IDX_W:0]   clr_cnt;
    logic             last_set;
    logic             clearing;
    logic             busy;
    logic             wr_rdy;
    logic             rd_rdy;
    logic             fl_rdy;
    logic             write_fire;
    logic             flush_fire;
    logic             read_fire;

    logic [NWAYS-1:0] ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [MW-1:0]    ram_wdata;
    logic [MW-1:0]    ram_rdata [NWAYS];
    meta_t            rd_meta   [NWAYS];

    logic             resp_valid;
    logic [TAG_W-1:0] probe_tag;

    assign last_set = (clr_cnt == LAST_SET);
    assign clearing = (state == ST_CLEAR);

    // Flush outranks read, so a read is not taken in a cycle that also carries a flush.
    assign write_fire = bus.io_write_valid & wr_rdy;
    assign flush_fire = bus.io_flush_valid & fl_rdy;
    assign read_fire  = bus.io_read_valid & rd_rdy & ~bus.io_flush_valid;

    // State register: reset always restarts the clear sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR after the last set is written, re-enter on flush.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (last_set)   state_nxt = ST_IDLE;
            ST_IDLE:  if (flush_fire) state_nxt = ST_CLEAR;
            default:                  state_nxt = ST_CLEAR;
        endcase
    end

    // FSM outputs: busy while sweeping, readys only in IDLE with write taking precedence.
    always_comb begin
        busy   = (state == ST_CLEAR);
        wr_rdy = (state == ST_IDLE);
        rd_rdy = (state == ST_IDLE) & ~bus.io_write_valid;
        fl_rdy = (state == ST_IDLE) & ~bus.io_write_valid;
    end

    assign bus.io_busy        = busy;
    assign bus.io_write_ready = wr_rdy;
    assign bus.io_read_ready  = rd_rdy;
    assign bus.io_flush_ready = fl_rdy;

    // Sweep counter: restarts at set 0 on flush, stops on the last set instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (flush_fire) begin
            clr_cnt <= '0;
        end else if (clearing && !last_set) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Array write port: the sweep zeroes every way, otherwise only enabled ways take write data.
    always_comb begin
        ram_waddr = clearing ? clr_cnt[IDX_W-1:0] : bus.io_write_bits_idx;
        ram_wdata = clearing ? '0
                             : {bus.io_write_bits_data_tag, bus.io_write_bits_data_coh_state};
        for (int w = 0; w < NWAYS; w++) begin
            ram_we[w] = clearing | (write_fire & bus.io_write_bits_way_en[w]);
        end
    end

    for (genvar g = 0; g < NWAYS; g++) begin : g_way
        metadata_way_ram #(
            .NSETS  (NSETS),
            .ADDR_W (IDX_W),
            .WIDTH  (MW)
        ) u_ram (
            .clk   (clk),
            .we    (ram_we[g]),
            .waddr (ram_waddr),
            .wdata (ram_wdata),
            .re    (read_fire),
            .raddr (bus.io_read_bits_idx),
            .rdata (ram_rdata[g])
        );
    end

    // Response valid: one cycle after a read handshake, dropped by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= read_fire;
        end
    end

    // Probe tag captured alongside the read so the compare sees only registered values.
    always_ff @(posedge clk) begin
        if (read_fire) begin
            probe_tag <= bus.io_read_bits_tag;
        end
    end

    // Unpack each way, drive per-way data and qualify the hit with a valid response.
    always_comb begin
        bus.io_resp_tag       = '0;
        bus.io_resp_coh_state = '0;
        bus.io_resp_hit       = '0;
        for (int w = 0; w < NWAYS; w++) begin
            rd_meta[w] = '0;
            rd_meta[w].tag[TAG_W-1:0]       = ram_rdata[w][COH_W +: TAG_W];
            rd_meta[w].coh_state[COH_W-1:0] = ram_rdata[w][COH_W-1:0];
            bus.io_resp_tag[w*TAG_W +: TAG_W]       = rd_meta[w].tag[TAG_W-1:0];
            bus.io_resp_coh_state[w*COH_W +: COH_W] = rd_meta[w].coh_state[COH_W-1:0];
            bus.io_resp_hit[w] = resp_valid
                               & (rd_meta[w].tag == TAG_MAX_W'(probe_tag))
                               & (rd_meta[w].coh_state != COH_INVALID);
        end
    end

    assign bus.io_resp_valid = resp_valid;

endmodule

// File: tb/tb_metadata_array_nway.sv
// tb/tb_metadata_array_nway.sv - self-checking bench for metadata_array_nway
module tb_metadata_array_nway;

    localparam int NSETS = 128;
    localparam int NWAYS = 4;
    localparam int TAG_W = 19;
    localparam int COH_W = 2;
    localparam int IDX_W = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    metadata_array_nway_if #(.NSETS(NSETS), .NWAYS(NWAYS), .TAG_W(TAG_W), .COH_W(COH_W)) bus ();

    metadata_array_nway #(.NSETS(NSETS), .NWAYS(NWAYS), .TAG_W(TAG_W), .COH_W(COH_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int pass_cnt = 0;
    int total    = 0;

    logic [TAG_W-1:0] m_tag [NSETS][NWAYS];
    logic [COH_W-1:0] m_coh [NSETS][NWAYS];

    logic [NWAYS*TAG_W-1:0] last_tags;
    logic [NWAYS*COH_W-1:0] last_cohs;
    bit                     have_last = 0;

    function automatic logic [NWAYS*TAG_W-1:0] exp_tags(input int idx);
        logic [NWAYS*TAG_W-1:0] r;
        for (int w = 0; w < NWAYS; w++) r[w*TAG_W +: TAG_W] = m_tag[idx][w];
        return r;
    endfunction

    function automatic logic [NWAYS*COH_W-1:0] exp_cohs(input int idx);
        logic [NWAYS*COH_W-1:0] r;
        for (int w = 0; w < NWAYS; w++) r[w*COH_W +: COH_W] = m_coh[idx][w];
        return r;
    endfunction

    function automatic logic [NWAYS-1:0] exp_hit(input int idx, input logic [TAG_W-1:0] tag);
        logic [NWAYS-1:0] r;
        for (int w = 0; w < NWAYS; w++) r[w] = (m_tag[idx][w] == tag) && (m_coh[idx][w] != 0);
        return r;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < NWAYS; w++) begin
                m_tag[s][w] = '0;
                m_coh[s][w] = '0;
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.io_read_valid                = 1'b0;
        bus.io_read_bits_idx             = '0;
        bus.io_read_bits_tag             = '0;
        bus.io_write_valid               = 1'b0;
        bus.io_write_bits_idx            = '0;
        bus.io_write_bits_way_en         = '0;
        bus.io_write_bits_data_tag       = '0;
        bus.io_write_bits_data_coh_state = '0;
        bus.io_flush_valid               = 1'b0;
    endtask

    task automatic set_write(input int idx, input logic [NWAYS-1:0] en,
                             input logic [TAG_W-1:0] tag, input logic [COH_W-1:0] coh);
        bus.io_write_valid               = 1'b1;
        bus.io_write_bits_idx            = IDX_W'(idx);
        bus.io_write_bits_way_en         = en;
        bus.io_write_bits_data_tag       = tag;
        bus.io_write_bits_data_coh_state = coh;
    endtask

    task automatic model_write(input int idx, input logic [NWAYS-1:0] en,
                               input logic [TAG_W-1:0] tag, input logic [COH_W-1:0] coh);
        for (int w = 0; w < NWAYS; w++)
            if (en[w]) begin
                m_tag[idx][w] = tag;
                m_coh[idx][w] = coh;
            end
    endtask

    // Issue one write in IDLE and mirror it into the model.
    task automatic do_write(input int idx, input logic [NWAYS-1:0] en,
                            input logic [TAG_W-1:0] tag, input logic [COH_W-1:0] coh);
        set_write(idx, en, tag, coh);
        tick();
        bus.io_write_valid = 1'b0;
        model_write(idx, en, tag, coh);
    endtask

    // Issue one read in IDLE; on return the response cycle is being observed.
    task automatic do_read(input int idx, input logic [TAG_W-1:0] tag);
        bus.io_read_valid    = 1'b1;
        bus.io_read_bits_idx = IDX_W'(idx);
        bus.io_read_bits_tag = tag;
        tick();
        bus.io_read_valid = 1'b0;
    endtask

    task automatic count_busy(output int n, output bit rdy_ok);
        n = 0;
        rdy_ok = 1;
        while (bus.io_busy === 1'b1 && n < 1000) begin
            if (bus.io_write_ready !== 1'b0 || bus.io_read_ready !== 1'b0 ||
                bus.io_flush_ready !== 1'b0) rdy_ok = 0;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int  n;
        bit  ok;
        idle_inputs();
        rst_n = 1'b0;
        #3;
        total++; if (bus.io_busy !== 1'b1) $display("FAIL reset_busy got %b want 1", bus.io_busy); else pass_cnt++;
        total++; if ({bus.io_write_ready, bus.io_read_ready, bus.io_flush_ready} !== 3'b000)
            $display("FAIL reset_readys got %b want 000", {bus.io_write_ready, bus.io_read_ready, bus.io_flush_ready});
        else pass_cnt++;
        total++; if (bus.io_resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", bus.io_resp_valid); else pass_cnt++;
        total++; if (bus.io_resp_hit !== '0) $display("FAIL reset_resp_hit got %b want 0", bus.io_resp_hit); else pass_cnt++;
        tick();
        tick();
        rst_n = 1'b1;
        count_busy(n, ok);
        total++; if (n != NSETS) $display("FAIL reset_sweep_len got %0d want %0d", n, NSETS); else pass_cnt++;
        total++; if (ok !== 1'b1) $display("FAIL reset_sweep_readys got ready during sweep want none"); else pass_cnt++;
        total++; if (bus.io_write_ready !== 1'b1) $display("FAIL reset_write_ready got %b want 1", bus.io_write_ready); else pass_cnt++;
        total++; if (bus.io_read_ready !== 1'b1) $display("FAIL reset_read_ready got %b want 1", bus.io_read_ready); else pass_cnt++;
        model_clear();
    endtask

    task automatic test_write_read();
        logic [NWAYS*TAG_W-1:0] tags;
        do_write(5, 4'b0100, 19'h1234, 2'd2);
        bus.io_read_valid    = 1'b1;
        bus.io_read_bits_idx = 7'd5;
        bus.io_read_bits_tag = 19'h1234;
        #1;
        total++; if (bus.io_read_ready !== 1'b1) $display("FAIL wr_rd_read_ready got %b want 1", bus.io_read_ready); else pass_cnt++;
        tick();
        bus.io_read_valid = 1'b0;
        tags = bus.io_resp_tag;
        total++; if (bus.io_resp_valid !== 1'b1) $display("FAIL wr_rd_valid got %b want 1", bus.io_resp_valid); else pass_cnt++;
        total++; if (bus.io_resp_hit !== 4'b0100) $display("FAIL wr_rd_hit got %b want 0100", bus.io_resp_hit); else pass_cnt++;
        total++; if (tags[2*TAG_W +: TAG_W] !== 19'h1234) $display("FAIL wr_rd_way2_tag got %h want 1234", tags[2*TAG_W +: TAG_W]); else pass_cnt++;
        total++; if (bus.io_resp_tag !== exp_tags(5)) $display("FAIL wr_rd_tags got %h want %h", bus.io_resp_tag, exp_tags(5)); else pass_cnt++;
        total++; if (bus.io_resp_coh_state !== 8'b0010_0000) $display("FAIL wr_rd_cohs got %b want 00100000", bus.io_resp_coh_state); else pass_cnt++;
        tick();
        total++; if (bus.io_resp_valid !== 1'b0) $display("FAIL wr_rd_valid_drop got %b want 0", bus.io_resp_valid); else pass_cnt++;
        total++; if (bus.io_resp_hit !== 4'b0000) $display("FAIL wr_rd_hit_drop got %b want 0000", bus.io_resp_hit); else pass_cnt++;
        total++; if (bus.io_resp_tag !== tags) $display("FAIL wr_rd_tag_hold got %h want %h", bus.io_resp_tag, tags); else pass_cnt++;
    endtask

    task automatic test_priority();
        logic [TAG_W-1:0] t;
        t = 19'($urandom_range(1, 19'h7ffff));
        set_write(9, 4'b0011, t, 2'd1);
        bus.io_read_valid    = 1'b1;
        bus.io_read_bits_idx = 7'd9;
        bus.io_read_bits_tag = t;
        #1;
        total++; if (bus.io_read_ready !== 1'b0) $display("FAIL prio_read_ready got %b want 0", bus.io_read_ready); else pass_cnt++;
        total++; if (bus.io_write_ready !== 1'b1) $display("FAIL prio_write_ready got %b want 1", bus.io_write_ready); else pass_cnt++;
        total++; if (bus.io_flush_ready !== 1'b0) $display("FAIL prio_flush_ready got %b want 0", bus.io_flush_ready); else pass_cnt++;
        tick();
        bus.io_write_valid = 1'b0;
        model_write(9, 4'b0011, t, 2'd1);
        total++; if (bus.io_resp_valid !== 1'b0) $display("FAIL prio_no_read got %b want 0", bus.io_resp_valid); else pass_cnt++;
        #1;
        total++; if (bus.io_read_ready !== 1'b1) $display("FAIL prio_read_ready2 got %b want 1", bus.io_read_ready); else pass_cnt++;
        tick();
        bus.io_read_valid = 1'b0;
        total++; if (bus.io_resp_valid !== 1'b1) $display("FAIL prio_resp_valid got %b want 1", bus.io_resp_valid); else pass_cnt++;
        total++; if (bus.io_resp_hit !== 4'b0011) $display("FAIL prio_hit got %b want 0011", bus.io_resp_hit); else pass_cnt++;
        total++; if (bus.io_resp_tag !== exp_tags(9)) $display("FAIL prio_tags got %h want %h", bus.io_resp_tag, exp_tags(9)); else pass_cnt++;
    endtask

    task automatic test_hit_state0();
        logic [TAG_W-1:0] t;
        t = 19'h2abcd;
        do_write(20, 4'b1111, t, 2'd3);
        do_write(20, 4'b0010, t, 2'd0);
        do_read(20, t);
        total++; if (bus.io_resp_hit !== 4'b1101) $display("FAIL st0_hit got %b want 1101", bus.io_resp_hit); else pass_cnt++;
        total++; if (bus.io_resp_coh_state !== exp_cohs(20)) $display("FAIL st0_cohs got %b want %b", bus.io_resp_coh_state, exp_cohs(20)); else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        int               op, idx;
        logic [NWAYS-1:0] en;
        logic [TAG_W-1:0] tag;
        logic [COH_W-1:0] coh;
        for (int i = 0; i < 300; i++) begin
            op  = int'($urandom_range(0, 2));
            idx = int'($urandom_range(0, 7));
            tag = 19'($urandom_range(0, 3));
            if (op == 0) begin
                en  = 4'($urandom_range(0, 15));
                coh = 2'($urandom_range(0, 3));
                do_write(idx, en, tag, coh);
            end else if (op == 1) begin
                do_read(idx, tag);
                total++; if (bus.io_resp_valid !== 1'b1) $display("FAIL rnd_valid i=%0d got %b want 1", i, bus.io_resp_valid); else pass_cnt++;
                total++; if (bus.io_resp_tag !== exp_tags(idx)) $display("FAIL rnd_tags i=%0d got %h want %h", i, bus.io_resp_tag, exp_tags(idx)); else pass_cnt++;
                total++; if (bus.io_resp_coh_state !== exp_cohs(idx)) $display("FAIL rnd_cohs i=%0d got %b want %b", i, bus.io_resp_coh_state, exp_cohs(idx)); else pass_cnt++;
                total++; if (bus.io_resp_hit !== exp_hit(idx, tag)) $display("FAIL rnd_hit i=%0d got %b want %b", i, bus.io_resp_hit, exp_hit(idx, tag)); else pass_cnt++;
                last_tags = exp_tags(idx);
                last_cohs = exp_cohs(idx);
                have_last = 1;
            end else begin
                tick();
                total++; if (bus.io_resp_valid !== 1'b0) $display("FAIL rnd_idle_valid i=%0d got %b want 0", i, bus.io_resp_valid); else pass_cnt++;
                total++; if (bus.io_resp_hit !== 4'b0000) $display("FAIL rnd_idle_hit i=%0d got %b want 0000", i, bus.io_resp_hit); else pass_cnt++;
                if (have_last) begin
                    total++; if ({bus.io_resp_tag, bus.io_resp_coh_state} !== {last_tags, last_cohs})
                        $display("FAIL rnd_hold i=%0d got %h want %h", i, {bus.io_resp_tag, bus.io_resp_coh_state}, {last_tags, last_cohs});
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [TAG_W-1:0] probes [4];
        for (int i = 0; i < 4; i++) begin
            probes[i] = 19'($urandom_range(0, 19'h7ffff));
            do_write(40 + i, 4'($urandom_range(1, 15)), probes[i], 2'($urandom_range(1, 3)));
        end
        bus.io_read_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.io_read_bits_idx = IDX_W'(40 + i);
            bus.io_read_bits_tag = probes[i];
            tick();
            total++; if (bus.io_resp_valid !== 1'b1) $display("FAIL b2b_valid i=%0d got %b want 1", i, bus.io_resp_valid); else pass_cnt++;
            total++; if (bus.io_resp_tag !== exp_tags(40 + i)) $display("FAIL b2b_tags i=%0d got %h want %h", i, bus.io_resp_tag, exp_tags(40 + i)); else pass_cnt++;
            total++; if (bus.io_resp_hit !== exp_hit(40 + i, probes[i])) $display("FAIL b2b_hit i=%0d got %b want %b", i, bus.io_resp_hit, exp_hit(40 + i, probes[i])); else pass_cnt++;
        end
        bus.io_read_valid = 1'b0;
        tick();
        total++; if (bus.io_resp_valid !== 1'b0) $display("FAIL b2b_end_valid got %b want 0", bus.io_resp_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        int n;
        bit ok;
        logic [TAG_W-1:0] ta, tb;
        ta = 19'h0beef;
        tb = 19'h05a5a;
        do_write(0, 4'b1111, ta, 2'd1);
        do_write(127, 4'b1111, ta, 2'd3);
        bus.io_flush_valid = 1'b1;
        #1;
        total++; if (bus.io_flush_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", bus.io_flush_ready); else pass_cnt++;
        tick();
        bus.io_flush_valid = 1'b0;
        set_write(3, 4'b1000, tb, 2'd2);
        count_busy(n, ok);
        total++; if (n != NSETS) $display("FAIL flush_sweep_len got %0d want %0d", n, NSETS); else pass_cnt++;
        total++; if (ok !== 1'b1) $display("FAIL flush_sweep_readys got ready during sweep want none"); else pass_cnt++;
        model_clear();
        tick();
        bus.io_write_valid = 1'b0;
        model_write(3, 4'b1000, tb, 2'd2);
        do_read(0, ta);
        total++; if (bus.io_resp_hit !== 4'b0000) $display("FAIL flush_set0_hit got %b want 0000", bus.io_resp_hit); else pass_cnt++;
        total++; if (bus.io_resp_coh_state !== 8'h00) $display("FAIL flush_set0_coh got %b want 0", bus.io_resp_coh_state); else pass_cnt++;
        do_read(127, ta);
        total++; if (bus.io_resp_hit !== 4'b0000) $display("FAIL flush_set127_hit got %b want 0000", bus.io_resp_hit); else pass_cnt++;
        total++; if (bus.io_resp_coh_state !== 8'h00) $display("FAIL flush_set127_coh got %b want 0", bus.io_resp_coh_state); else pass_cnt++;
        do_read(3, tb);
        total++; if (bus.io_resp_hit !== exp_hit(3, tb)) $display("FAIL flush_held_write got %b want %b", bus.io_resp_hit, exp_hit(3, tb)); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        bit ok;
        logic [TAG_W-1:0] t;
        t = 19'h13579;
        do_write(50, 4'b1111, t, 2'd3);
        bus.io_read_valid    = 1'b1;
        bus.io_read_bits_idx = 7'd50;
        bus.io_read_bits_tag = t;
        #1;
        rst_n = 1'b0;
        #1;
        bus.io_read_valid = 1'b0;
        total++; if (bus.io_read_ready !== 1'b0) $display("FAIL rst_read_ready got %b want 0", bus.io_read_ready); else pass_cnt++;
        tick();
        total++; if (bus.io_resp_valid !== 1'b0) $display("FAIL rst_drop_resp got %b want 0", bus.io_resp_valid); else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        rst_n = 1'b0;
        #1;
        total++; if (bus.io_busy !== 1'b1) $display("FAIL rst_mid_busy got %b want 1", bus.io_busy); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        count_busy(n, ok);
        total++; if (n != NSETS) $display("FAIL rst_mid_sweep_len got %0d want %0d", n, NSETS); else pass_cnt++;
        model_clear();
        do_read(50, t);
        total++; if (bus.io_resp_hit !== 4'b0000) $display("FAIL rst_mid_hit got %b want 0000", bus.io_resp_hit); else pass_cnt++;
        total++; if (bus.io_resp_tag !== exp_tags(50)) $display("FAIL rst_mid_tags got %h want %h", bus.io_resp_tag, exp_tags(50)); else pass_cnt++;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_priority();
        test_hit_state0();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
